// File: rtl/crc16_framer.sv
// Transmit frame builder: forwards payload bytes through a one-deep output register
// and appends the CRC-16/CCITT-FALSE of each frame as two trailing bytes, MSB first.
module crc16_framer #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  data_out,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] crc_out,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    CRC_HI  = 2'd1,
    CRC_LO  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] crc;
  logic        load;

  // Bit-serial CRC update over one byte, MSB first, no reflection.
  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // The output register can take a new byte when empty or draining this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = (state == PAYLOAD) && load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PAYLOAD;
      crc       <= INIT;
      data_out  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      crc_out   <= 16'h0000;
      frame_cnt <= 16'h0000;
    end else if (load) begin
      case (state)
        PAYLOAD: begin
          if (in_valid) begin
            data_out  <= data_in;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            crc       <= crc8(crc, data_in);
            if (in_last) state <= CRC_HI;
          end else begin
            out_valid <= 1'b0;
          end
        end
        CRC_HI: begin
          data_out  <= crc[15:8];
          out_last  <= 1'b0;
          out_valid <= 1'b1;
          state     <= CRC_LO;
        end
        CRC_LO: begin
          data_out  <= crc[7:0];
          out_last  <= 1'b1;
          out_valid <= 1'b1;
          crc_out   <= crc;
          frame_cnt <= frame_cnt + 16'd1;
          crc       <= INIT;
          state     <= PAYLOAD;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= PAYLOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_framer.sv
// Directed bench for crc16_framer: table of frames plus hand-written multi-cycle sequences.
module tb_crc16_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] crc_out;
  logic [15:0] frame_cnt;

  crc16_framer dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .crc_out(crc_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [7:0]  b [9];
    bit          rnd;
    logic [15:0] crc;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] in_q  [$];
  logic [8:0] out_q [$];
  int         gaps  [$];

  logic       lat_pend   = 1'b0;
  logic [7:0] lat_byte   = 8'h00;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out   = 9'h000;
  logic [15:0] exp_cnt   = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // One cycle: drive at negedge, sample 1ns later (values the next posedge sees).
  task automatic step(input logic iv, input logic [8:0] din, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    data_in   = din[7:0];
    in_last   = din[8];
    out_ready = ordy;
    #1;
    if (lat_pend) begin
      check("latency", 32'({out_valid, data_out}), 32'({1'b1, lat_byte}));
      lat_pend = 1'b0;
    end
    if (prev_stall) check("hold", 32'({out_valid, out_last, data_out}), 32'({1'b1, prev_out}));
    acc = iv && in_ready;
    if (acc) begin
      lat_pend = 1'b1;
      lat_byte = din[7:0];
    end
    if (out_valid && out_ready) out_q.push_back({out_last, data_out});
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_last, data_out};
  endtask

  task automatic run_stream(input bit rnd);
    int   idx = 0;
    int   gap = 0;
    int   n_out;
    int   budget = 0;
    bit   after_last = 1'b0;
    logic a;
    logic [8:0] d;
    n_out = in_q.size();
    foreach (in_q[k]) if (in_q[k][8]) n_out += 2;
    while ((idx < in_q.size() || out_q.size() < n_out) && budget < 400) begin
      d = (idx < in_q.size()) ? in_q[idx] : 9'h000;
      step(idx < in_q.size(), d, rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
      if (a) begin
        if (after_last) gaps.push_back(gap);
        after_last = d[8];
        gap = 0;
        idx++;
      end else if (after_last && idx < in_q.size()) begin
        gap++;
      end
      budget++;
    end
    check("drain_count", 32'(out_q.size()), 32'(n_out));
    for (int k = 0; k < 3; k++) step(1'b0, 9'h000, 1'b1, a);
    check("no_extra", 32'(out_q.size()), 32'(n_out));
  endtask

  task automatic push_123456789();
    for (int i = 0; i < 9; i++) in_q.push_back({(i == 8), 8'(8'h31 + i)});
  endtask

  task automatic cmp_frame(input string name, input int base, input int n,
                           input logic [7:0] b [9], input logic [15:0] c);
    logic [8:0] got, exp;
    for (int j = 0; j < n + 2; j++) begin
      got = (base + j < out_q.size()) ? out_q[base + j] : 9'h1FF;
      if (j < n)       exp = {1'b0, b[j]};
      else if (j == n) exp = {1'b0, c[15:8]};
      else             exp = {1'b1, c[7:0]};
      check($sformatf("%s_byte%0d", name, j), 32'(got), 32'(exp));
    end
  endtask

  vec_t       vt [3];
  logic [7:0] b_asc [9];
  logic [7:0] b_zero [9];
  logic       a;
  int         nl;
  logic [15:0] res;

  initial begin
    for (int i = 0; i < 9; i++) begin
      b_asc[i]  = 8'(8'h31 + i);
      b_zero[i] = 8'h00;
    end
    vt[0].n = 9; vt[0].b = b_asc;  vt[0].rnd = 1'b0; vt[0].crc = 16'h29B1;
    vt[1].n = 1; vt[1].b = b_zero; vt[1].rnd = 1'b0; vt[1].crc = 16'hE1F0;
    vt[2].n = 9; vt[2].b = b_asc;  vt[2].rnd = 1'b1; vt[2].crc = 16'h29B1;

    rst = 1'b1; data_in = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_crc_out", 32'(crc_out), 32'h0000);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0000);
    @(negedge clk); rst = 1'b0; #1;
    check("in_ready_after_rst", 32'(in_ready), 32'h1);

    for (int t = 0; t < 3; t++) begin
      in_q.delete(); out_q.delete(); gaps.delete();
      for (int i = 0; i < vt[t].n; i++) in_q.push_back({(i == vt[t].n - 1), vt[t].b[i]});
      run_stream(vt[t].rnd);
      exp_cnt = exp_cnt + 16'd1;
      cmp_frame($sformatf("vec%0d", t), 0, vt[t].n, vt[t].b, vt[t].crc);
      check($sformatf("vec%0d_crc_out", t), 32'(crc_out), 32'(vt[t].crc));
      check($sformatf("vec%0d_frame_cnt", t), 32'(frame_cnt), 32'(exp_cnt));
    end

    // Back-to-back frames with no idle gap between them.
    in_q.delete(); out_q.delete(); gaps.delete();
    push_123456789();
    in_q.push_back(9'h100);
    run_stream(1'b0);
    exp_cnt = exp_cnt + 16'd2;
    cmp_frame("b2b_f0", 0, 9, b_asc, 16'h29B1);
    cmp_frame("b2b_f1", 11, 1, b_zero, 16'hE1F0);
    check("b2b_gap", 32'((gaps.size() > 0) ? gaps[0] : -1), 32'd2);
    check("b2b_crc_out", 32'(crc_out), 32'hE1F0);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    res = 16'hFFFF;
    for (int j = 0; j < 11 && j < out_q.size(); j++) res = crc_model(res, out_q[j][7:0]);
    check("b2b_residue0", 32'(res), 32'h0000);
    res = 16'hFFFF;
    for (int j = 11; j < 14 && j < out_q.size(); j++) res = crc_model(res, out_q[j][7:0]);
    check("b2b_residue1", 32'(res), 32'h0000);

    // Reset in the middle of a frame.
    in_q.delete(); out_q.delete(); gaps.delete();
    for (int i = 0; i < 4; i++) begin
      a = 1'b0;
      for (int k = 0; k < 20 && !a; k++) step(1'b1, {1'b0, 8'(8'hA0 + i)}, 1'b1, a);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    lat_pend = 1'b0;
    prev_stall = 1'b0;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_last", 32'(out_last), 32'h0);
    check("midrst_crc_out", 32'(crc_out), 32'h0000);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'h0000);
    @(negedge clk); rst = 1'b0;
    nl = 0;
    foreach (out_q[k]) if (out_q[k][8]) nl++;
    check("midrst_no_trailer", 32'(nl), 32'd0);
    step(1'b0, 9'h000, 1'b1, a);
    check("midrst_idle_out_valid", 32'(out_valid), 32'h0);
    in_q.delete(); out_q.delete();
    push_123456789();
    run_stream(1'b0);
    exp_cnt = 16'd1;
    cmp_frame("postrst", 0, 9, b_asc, 16'h29B1);
    check("postrst_crc_out", 32'(crc_out), 32'h29B1);
    check("postrst_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    in_q.delete(); out_q.delete();
    in_q.push_back(9'h100);
    run_stream(1'b0);
    cmp_frame("wrap", 0, 1, b_zero, 16'hE1F0);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
